execute_unit: RTL and testbench
===============================

# execute_unit

Parametrised execute stage that follows the single-cycle ALU wrapper. It keeps the data2/data3 operand select and the ALU opcodes. It adds a registered output with a valid/ready handshake, a persistent NZVC flag register with write enable, register-tag passthrough, and an iterative shift-add multiplier behind a compile-time switch. It sits between decode/operand-fetch and memory/writeback. Backpressure reaches decode through `inReady`.

## Interface
- `WIDTH`, 8: datapath width in bits (≥4).
- `TAGW`, 4: destination register tag width.
- `clk` in 1: clock, all state on rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `inValid` in 1: operation presented.
- `inReady` out 1: operation accepted this edge when `inValid && inReady`.
- `data1` in WIDTH: operand A.
- `data2` in WIDTH: operand B, register source.
- `data3` in WIDTH: operand B, immediate/forwarded source.
- `data2Selector` in 1: 0 selects `data2`, 1 selects `data3`.
- `aluControl` in 4: opcode.
- `flagWrite` in 1: update NZVC when this op's result is written.
- `destIn` in TAGW: destination tag carried with the op.
- `outValid` out 1: `aluOutput`/`destOut` hold a result.
- `outReady` in 1: consumer takes the result this edge when `outValid && outReady`.
- `aluOutput` out WIDTH: registered result.
- `destOut` out TAGW: tag of the result.
- `N`, `Z`, `V`, `C` out 1 each: flag register.
- `busy` out 1: multiplier iterating.

## Operation
- B = `data2Selector ? data3 : data2`. A, B, opcode, `flagWrite` and tag are captured at accept.
- Opcodes:
  - 0 ADD: C = carry out, V = signed overflow.
  - 1 SUB (A−B): C = 1 when A ≥ B unsigned (no borrow), V = signed overflow.
  - 2 AND, 3 OR, 4 XOR: C = 0, V = 0.
  - 5 SHL, 6 SHR (logical): amount = B[$clog2(WIDTH)-1:0]. C = last bit shifted out (0 if amount 0), V = 0.
  - 7 PASSB: result B, C = 0, V = 0.
  - 8 MUL (see Configuration).
  - 9–15: result 0, flags treated as PASSB.
- All opcodes: N = result[WIDTH-1], Z = (result == 0). Flags are written only if the captured `flagWrite` = 1, on the same edge the result enters the output register. Otherwise they hold.
- Handshake: `inReady = !busy && (!outValid || outReady)`. Output register and flags hold while `outValid && !outReady`. `outValid` clears on consumption if nothing new is written that edge.
- FSM states:
  - IDLE: accept single-cycle op → write output on the accept edge. Accept MUL → MULT with counter = 0, multiplicand = A, multiplier = B, accumulator (2·WIDTH) = 0.
  - MULT: each edge adds the shifted multiplicand if the multiplier LSB is 1, then shifts. When counter = WIDTH−1, write the low WIDTH bits to the output, set `outValid`, and return to IDLE. Otherwise increment the counter.
- MUL flags: V = C = (upper WIDTH product bits ≠ 0).
- The output register is guaranteed empty when MUL completes, because accept required a free output and no accepts occur while `busy`.

## Timing
- Reset (async assert, sync release), all outputs:
  - `outValid`=0, `aluOutput`=0, `destOut`=0.
  - N=Z=V=C=0.
  - `busy`=0, `inReady`=1.
  - FSM IDLE.
- Single-cycle op: accepted at edge E0 → `outValid`=1 with result after E0. Latency 1. Back-to-back throughput 1/cycle with `outReady`=1.
- MUL: accepted at E0 → `busy`=1 after E0. Result and `outValid` appear after edge E_WIDTH. `busy` falls on the same edge. Latency WIDTH.
- Simultaneous consume and accept: the old result leaves and the new one is written on the same edge; `outValid` stays 1.
- Reset mid-MUL: iteration aborts, no result produced, flags cleared.
- `inValid` with `inReady`=0: no capture. Inputs may change freely.

## Configuration
- `EXECUTE_MUL_EN` defined: multiplier, MULT state and `busy` logic present. Opcode 8 behaves as above.
- Not defined: no multiplier logic, `busy` tied 0. Opcode 8 takes the 9–15 path: single cycle, result 0, C = V = 0, Z = 1.

## Test plan
- WIDTH=8, ADD 0x7F+0x01, `flagWrite`=1, `outReady`=1 → next cycle `aluOutput`=0x80, N=1 Z=0 V=1 C=0.
- SUB 0x05−0x05 via `data3` (`data2Selector`=1), tag 3 → 0x00, Z=1, C=1, V=0, `destOut`=3. Following AND with `flagWrite`=0 leaves Z=1.
- `outReady`=0 for 3 cycles after an OR result → `aluOutput` stable, `inReady`=0, a second op is not accepted until `outReady`=1.
- MUL 0x10×0x11 (`EXECUTE_MUL_EN` on) → `busy` for 8 cycles, then `aluOutput`=0x10, V=C=1. MUL 0x03×0x05 → 0x0F, V=C=0.
- Assert `reset` low at MUL step 4 → all outputs zero immediately, no result after release, next ADD 0x01+0x01 returns 0x02 after 1 cycle.
- `EXECUTE_MUL_EN` off, opcode 8 → 1-cycle result 0x00, Z=1, `busy` never asserted.

Source files
------------

// File: rtl/execute_unit.sv
// Execute stage: registered ALU result with valid/ready handshake, NZVC flag register and tag passthrough.
// Optional iterative shift-add multiplier (opcode 8) enabled by defining EXECUTE_MUL_EN.
module execute_unit #(
  parameter int WIDTH = 8,
  parameter int TAGW  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inValid,
  output logic             inReady,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic [WIDTH-1:0] data3,
  input  logic             data2Selector,
  input  logic [3:0]       aluControl,
  input  logic             flagWrite,
  input  logic [TAGW-1:0]  destIn,
  output logic             outValid,
  input  logic             outReady,
  output logic [WIDTH-1:0] aluOutput,
  output logic [TAGW-1:0]  destOut,
  output logic             N,
  output logic             Z,
  output logic             V,
  output logic             C,
  output logic             busy
);

  localparam int SW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_XOR   = 4'd4,
    OP_SHL   = 4'd5,
    OP_SHR   = 4'd6,
    OP_PASSB = 4'd7,
    OP_MUL   = 4'd8
  } op_e;

  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] res;
  logic             res_c;
  logic             res_v;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shl_t;
  logic [WIDTH:0]   shr_t;
  logic [SW-1:0]    amt;
  logic             accept;
  logic             is_mul;

  always_comb begin
    opb   = data2Selector ? data3 : data2;
    amt   = opb[SW-1:0];
    sum   = '0;
    // One guard bit on each side captures the last bit shifted out (0 for amount 0).
    shl_t = {1'b0, data1} << amt;
    shr_t = {data1, 1'b0} >> amt;
    res   = '0;
    res_c = 1'b0;
    res_v = 1'b0;
    case (aluControl)
      OP_ADD: begin
        sum   = {1'b0, data1} + {1'b0, opb};
        res   = sum[WIDTH-1:0];
        res_c = sum[WIDTH];
        res_v = (data1[WIDTH-1] == opb[WIDTH-1]) && (res[WIDTH-1] != data1[WIDTH-1]);
      end
      OP_SUB: begin
        sum   = {1'b0, data1} - {1'b0, opb};
        res   = sum[WIDTH-1:0];
        res_c = ~sum[WIDTH];
        res_v = (data1[WIDTH-1] != opb[WIDTH-1]) && (res[WIDTH-1] != data1[WIDTH-1]);
      end
      OP_AND:   res = data1 & opb;
      OP_OR:    res = data1 | opb;
      OP_XOR:   res = data1 ^ opb;
      OP_SHL: begin
        res   = shl_t[WIDTH-1:0];
        res_c = shl_t[WIDTH];
      end
      OP_SHR: begin
        res   = shr_t[WIDTH:1];
        res_c = shr_t[0];
      end
      OP_PASSB: res = opb;
      default:  res = '0;
    endcase
  end

`ifdef EXECUTE_MUL_EN
  typedef enum logic {S_IDLE, S_MULT} state_e;

  state_e              state;
  logic [2*WIDTH-1:0]  acc;
  logic [2*WIDTH-1:0]  mcand;
  logic [2*WIDTH-1:0]  acc_nx;
  logic [WIDTH-1:0]    mplier;
  logic [SW-1:0]       cnt;
  logic                m_fw;
  logic [TAGW-1:0]     m_tag;
  logic                mult_done;
  logic                hi_nz;

  assign is_mul    = (aluControl == OP_MUL);
  assign busy      = (state == S_MULT);
  assign acc_nx    = mplier[0] ? (acc + mcand) : acc;
  assign hi_nz     = |acc_nx[2*WIDTH-1:WIDTH];
  assign mult_done = (state == S_MULT) && (cnt == SW'(WIDTH - 1));
`else
  assign is_mul = 1'b0;
  assign busy   = 1'b0;
`endif

  assign inReady = !busy && (!outValid || outReady);
  assign accept  = inValid && inReady;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      outValid  <= 1'b0;
      aluOutput <= '0;
      destOut   <= '0;
      {N, Z, V, C} <= '0;
`ifdef EXECUTE_MUL_EN
      state  <= S_IDLE;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      m_fw   <= 1'b0;
      m_tag  <= '0;
`endif
    end else begin
      if (accept && !is_mul) begin
        outValid  <= 1'b1;
        aluOutput <= res;
        destOut   <= destIn;
        if (flagWrite) {N, Z, V, C} <= {res[WIDTH-1], res == '0, res_v, res_c};
      end
`ifdef EXECUTE_MUL_EN
      // Output slot is known free here: MUL was accepted only with a free slot and nothing enters while busy.
      else if (mult_done) begin
        outValid  <= 1'b1;
        aluOutput <= acc_nx[WIDTH-1:0];
        destOut   <= m_tag;
        if (m_fw) {N, Z, V, C} <= {acc_nx[WIDTH-1], acc_nx[WIDTH-1:0] == '0, hi_nz, hi_nz};
      end
`endif
      else if (outValid && outReady) begin
        outValid <= 1'b0;
      end

`ifdef EXECUTE_MUL_EN
      case (state)
        S_IDLE: begin
          if (accept && is_mul) begin
            state  <= S_MULT;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, data1};
            mplier <= opb;
            m_fw   <= flagWrite;
            m_tag  <= destIn;
          end
        end
        S_MULT: begin
          acc    <= acc_nx;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          if (mult_done) state <= S_IDLE;
          else           cnt   <= cnt + 1'b1;
        end
        default: state <= S_IDLE;
      endcase
`endif
    end
  end

endmodule

// File: tb/tb_execute_unit.sv
// Scoreboard bench for execute_unit: directed scenarios plus randomized ops against an arithmetic reference model.
module tb_execute_unit;
  localparam int W = 8;
  localparam int T = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         inValid = 1'b0;
  logic         inReady;
  logic [W-1:0] data1 = '0, data2 = '0, data3 = '0;
  logic         data2Selector = 1'b0;
  logic [3:0]   aluControl = '0;
  logic         flagWrite = 1'b0;
  logic [T-1:0] destIn = '0;
  logic         outValid;
  logic         outReady = 1'b1;
  logic [W-1:0] aluOutput;
  logic [T-1:0] destOut;
  logic         N, Z, V, C;
  logic         busy;

  execute_unit #(.WIDTH(W), .TAGW(T)) dut (
    .clk(clk), .reset(reset), .inValid(inValid), .inReady(inReady),
    .data1(data1), .data2(data2), .data3(data3), .data2Selector(data2Selector),
    .aluControl(aluControl), .flagWrite(flagWrite), .destIn(destIn),
    .outValid(outValid), .outReady(outReady), .aluOutput(aluOutput),
    .destOut(destOut), .N(N), .Z(Z), .V(V), .C(C), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic [T-1:0] tag;
    logic [3:0]   nzvc;
  } exp_t;

  exp_t        sbq[$];
  int unsigned nvec = 0;
  int unsigned nmis = 0;
  logic [3:0]  mflags = '0;
  bit          rand_ready = 1'b0;

`ifdef EXECUTE_MUL_EN
  localparam bit MUL_ON = 1'b1;
`else
  localparam bit MUL_ON = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int to_signed(input int unsigned x);
    return (x >= (1 << (W - 1))) ? int'(x) - (1 << W) : int'(x);
  endfunction

  // Reference: plain integer arithmetic on unsigned/signed interpretations of the operands.
  function automatic exp_t model(input int unsigned a, input int unsigned b,
                                 input int unsigned op, input int unsigned tag);
    exp_t        e;
    int unsigned m = 1 << W;
    int unsigned r = 0;
    int unsigned amt = b % W;
    bit          c = 1'b0, v = 1'b0;
    int          s;
    case (op)
      0: begin r = (a + b) % m; c = (a + b) >= m; s = to_signed(a) + to_signed(b);
               v = (s > (1 << (W - 1)) - 1) || (s < -(1 << (W - 1))); end
      1: begin r = (a + m - b) % m; c = a >= b; s = to_signed(a) - to_signed(b);
               v = (s > (1 << (W - 1)) - 1) || (s < -(1 << (W - 1))); end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: begin r = (a << amt) % m; c = (amt != 0) && (((a >> (W - amt)) & 1) == 1); end
      6: begin r = a >> amt;       c = (amt != 0) && (((a >> (amt - 1)) & 1) == 1); end
      7: r = b;
      8: if (MUL_ON) begin r = (a * b) % m; c = (a * b) >= m; v = c; end
      default: r = 0;
    endcase
    e.res  = W'(r);
    e.tag  = T'(tag);
    e.nzvc = {r >= (1 << (W - 1)), r == 0, v, c};
    return e;
  endfunction

  // Called right after a rising edge; returns #1 after the accepting edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] d2, input logic [W-1:0] d3,
                       input bit sel, input logic [3:0] op, input bit fw, input logic [T-1:0] tag);
    exp_t e;
    int   waited = 0;
    data1 = a; data2 = d2; data3 = d3; data2Selector = sel;
    aluControl = op; flagWrite = fw; destIn = tag; inValid = 1'b1;
    @(negedge clk);
    while (!inReady && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!inReady) begin
      check("accept_timeout", 32'(inReady), 32'd1);
    end else begin
      e = model(a, sel ? d3 : d2, op, tag);
      if (fw) mflags = e.nzvc;
      else    e.nzvc = mflags;
      sbq.push_back(e);
    end
    @(posedge clk);
    #1 inValid = 1'b0;
  endtask

  // Monitor: pop and compare whenever a result is consumed.
  always @(negedge clk) begin
    if (reset && outValid && outReady) begin
      if (sbq.size() == 0) begin
        check("unexpected_output", 32'(aluOutput), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("result", 32'(aluOutput), 32'(e.res));
        check("tag", 32'(destOut), 32'(e.tag));
        check("nzvc", 32'({N, Z, V, C}), 32'(e.nzvc));
      end
    end
  end

  always @(posedge clk) begin
    if (rand_ready) #1 outReady = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis + 1);
    $fatal(1);
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_outValid"}, 32'(outValid), 32'd0);
    check({tag, "_aluOutput"}, 32'(aluOutput), 32'd0);
    check({tag, "_destOut"}, 32'(destOut), 32'd0);
    check({tag, "_nzvc"}, 32'({N, Z, V, C}), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_inReady"}, 32'(inReady), 32'd1);
  endtask

  initial begin
    int cycles;
    logic [3:0] rop;

    #1 reset = 1'b0;
    #2 check_all_zero("reset");
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;

    // ADD overflow into sign bit
    issue(8'h7F, 8'h01, 8'h00, 1'b0, 4'd0, 1'b1, 4'd1);
    check("add_latency_valid", 32'(outValid), 32'd1);
    // SUB equal operands via immediate path, then AND without flag write
    issue(8'h05, 8'hAA, 8'h05, 1'b1, 4'd1, 1'b1, 4'd3);
    issue(8'hFF, 8'h3C, 8'h00, 1'b0, 4'd2, 1'b0, 4'd4);
    check("and_z_held", 32'(Z), 32'd1);

    // Backpressure: OR result held for 3 cycles, second op waits
    issue(8'h0F, 8'hA0, 8'h00, 1'b0, 4'd3, 1'b1, 4'd5);
    outReady = 1'b0;
    fork
      issue(8'h3C, 8'h0F, 8'h00, 1'b0, 4'd4, 1'b1, 4'd6);
      begin
        repeat (3) begin
          @(negedge clk);
          check("bp_inReady", 32'(inReady), 32'd0);
          check("bp_hold", 32'(aluOutput), 32'hAF);
          check("bp_valid", 32'(outValid), 32'd1);
        end
        @(posedge clk);
        #1 outReady = 1'b1;
      end
    join

    // Shift boundaries: amount 0 and WIDTH-1
    issue(8'h81, 8'h00, 8'h00, 1'b0, 4'd5, 1'b1, 4'd7);
    issue(8'h81, 8'h07, 8'h00, 1'b0, 4'd6, 1'b1, 4'd8);
    issue(8'h03, 8'h07, 8'h00, 1'b0, 4'd5, 1'b1, 4'd9);

    // Opcode 8: iterative multiply when enabled, zero result otherwise
    issue(8'h10, 8'h11, 8'h00, 1'b0, 4'd8, 1'b1, 4'd10);
    cycles = 0;
    while (busy && cycles < 50) begin
      @(posedge clk); #1;
      cycles++;
    end
    check("mul_busy_cycles", 32'(cycles), MUL_ON ? 32'(W) : 32'd0);
    check("mul_valid_at_done", 32'(outValid), 32'd1);
    issue(8'h03, 8'h05, 8'h00, 1'b0, 4'd8, 1'b1, 4'd11);
    repeat (W + 2) @(posedge clk);
    #1;

    // Reset in the middle of an operation
    issue(8'h33, 8'h44, 8'h00, 1'b0, MUL_ON ? 4'd8 : 4'd0, 1'b1, 4'd12);
    outReady = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    #1 check_all_zero("midreset");
    sbq.delete();
    mflags = '0;
    @(negedge clk);
    reset = 1'b1;
    outReady = 1'b1;
    repeat (W + 4) @(posedge clk);
    #1 check("no_result_after_reset", 32'(outValid), 32'd0);
    issue(8'h01, 8'h01, 8'h00, 1'b0, 4'd0, 1'b1, 4'd2);
    check("post_reset_add_valid", 32'(outValid), 32'd1);
    check("post_reset_add_value", 32'(aluOutput), 32'h02);

    // Randomized ops with random consumer backpressure
    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      rop = 4'($urandom_range(0, 15));
      if (i < 100) rop = 4'($urandom_range(0, 8));
      issue(W'($urandom), W'($urandom), W'($urandom), 1'($urandom), rop,
            1'($urandom), T'($urandom));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    rand_ready = 1'b0;
    @(posedge clk);
    #2 outReady = 1'b1;
    cycles = 0;
    while (sbq.size() != 0 && cycles < 200) begin
      @(posedge clk);
      cycles++;
    end
    @(negedge clk);
    check("drain_empty", 32'(sbq.size()), 32'd0);
    check("final_busy", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
